// File: rtl/input_conditioner.sv
`timescale 1ns/1ps
// Input conditioner: two-flop synchronizer feeding a counter-based debouncer,
// with registered one-cycle pulses on each rising/falling debounced transition.
module input_conditioner #(
  parameter int counterwidth = 3,
  parameter int waittime     = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic noisysignal,
  output logic conditioned,
  output logic positiveedge,
  output logic negativeedge,
  output logic synchronizer0UT,
  output logic synchronizer1OUT
);

  localparam logic [counterwidth-1:0] count_zero  = {counterwidth{1'b0}};
  localparam logic [counterwidth-1:0] count_one   = counterwidth'(32'd1);
  localparam logic [counterwidth-1:0] count_limit = counterwidth'(waittime);

  logic                    sync0_r;
  logic                    sync1_r;
  logic                    cond_r;
  logic                    pos_r;
  logic                    neg_r;
  logic [counterwidth-1:0] count_r;

  logic                    cond_s;
  logic                    pos_s;
  logic                    neg_s;
  logic [counterwidth-1:0] count_s;

  // Two-stage synchronizer for the asynchronous raw input
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync0_r <= 1'b0;
      sync1_r <= 1'b0;
    end else begin
      sync0_r <= noisysignal;
      sync1_r <= sync0_r;
    end
  end

  // Debounce decision: the synchronized level must disagree for waittime+1 edges
  always_comb begin
    count_s = count_zero;
    cond_s  = cond_r;
    pos_s   = 1'b0;
    neg_s   = 1'b0;
    if (sync1_r == cond_r) begin
      count_s = count_zero;
    end else if (count_r != count_limit) begin
      count_s = count_r + count_one;
    end else begin
      count_s = count_zero;
      cond_s  = sync1_r;
      pos_s   = sync1_r;
      neg_s   = ~sync1_r;
    end
  end

  // Debounce state and edge pulse registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= count_zero;
      cond_r  <= 1'b0;
      pos_r   <= 1'b0;
      neg_r   <= 1'b0;
    end else begin
      count_r <= count_s;
      cond_r  <= cond_s;
      pos_r   <= pos_s;
      neg_r   <= neg_s;
    end
  end

  assign conditioned      = cond_r;
  assign positiveedge     = pos_r;
  assign negativeedge     = neg_r;
  assign synchronizer0UT  = sync0_r;
  assign synchronizer1OUT = sync1_r;

endmodule

// File: tb/tb_input_conditioner.sv
`timescale 1ns/1ps
// Bench for input_conditioner: reference model feeds a scoreboard queue drained
// by a negedge monitor, plus directed latency, glitch and reset scenarios.
module tb_input_conditioner;

  localparam int CW = 3;
  localparam int WT = 3;

  logic clk = 1'b0;
  logic reset_n;
  logic noisysignal;
  logic conditioned, positiveedge, negativeedge, synchronizer0UT, synchronizer1OUT;
  logic [4:0] outs;

  int checks = 0;
  int errors = 0;
  int pos_seen = 0;
  int neg_seen = 0;

  typedef struct packed {
    logic c;
    logic p;
    logic n;
    logic s0;
    logic s1;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  assign outs = {conditioned, positiveedge, negativeedge, synchronizer0UT, synchronizer1OUT};

  input_conditioner #(.counterwidth(CW), .waittime(WT)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .noisysignal      (noisysignal),
    .conditioned      (conditioned),
    .positiveedge     (positiveedge),
    .negativeedge     (negativeedge),
    .synchronizer0UT  (synchronizer0UT),
    .synchronizer1OUT (synchronizer1OUT)
  );

  // Reference model: the debounced level flips once the last WT+1 synchronized
  // samples all disagree with it; synchronizer is a two-sample delay line.
  logic m_s0, m_s1, m_c, m_flip;
  logic hist[$];
  exp_t m_exp;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s0 = 1'b0;
      m_s1 = 1'b0;
      m_c  = 1'b0;
      hist.delete();
      q.delete();
    end else begin
      m_flip = 1'b0;
      hist.push_back(m_s1);
      if (hist.size() > WT + 1) void'(hist.pop_front());
      if (hist.size() == WT + 1) begin
        m_flip = 1'b1;
        foreach (hist[i]) if (hist[i] == m_c) m_flip = 1'b0;
      end
      m_exp.p = m_flip & m_s1;
      m_exp.n = m_flip & ~m_s1;
      if (m_flip) begin
        m_c = m_s1;
        hist.delete();
      end
      m_s1 = m_s0;
      m_s0 = noisysignal;
      m_exp.c  = m_c;
      m_exp.s0 = m_s0;
      m_exp.s1 = m_s1;
      q.push_back(m_exp);
    end
  end

  // Monitor: compares DUT outputs against the scoreboard away from the active edge
  exp_t mon_exp;
  always @(negedge clk) begin
    if (!reset_n) begin
      checks++;
      if (outs !== 5'b00000) begin
        errors++;
        $display("FAIL reset_hold: got %b expected 00000", outs);
      end
    end else if (q.size() > 0) begin
      mon_exp = q.pop_front();
      checks++;
      if (outs !== mon_exp) begin
        errors++;
        $display("FAIL scoreboard @%0t: got c/p/n/s0/s1=%b expected %b", $time, outs, mon_exp);
      end
      if (positiveedge === 1'b1) pos_seen++;
      if (negativeedge === 1'b1) neg_seen++;
    end
  end

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // Index (0 = first edge after the call) of the edge after which conditioned == target
  task automatic latency(input logic target, output int edges);
    edges = 99;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (conditioned == target) begin
        edges = k;
        break;
      end
    end
  endtask

  int lat;
  int pos0, neg0;
  int mode, hold;

  initial begin
    reset_n     = 1'b0;
    noisysignal = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_state", int'(outs), 0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Rising input: synchronizer visibility and full debounce latency
    noisysignal = 1'b1;
    @(posedge clk);
    #1;
    check("sync0_after_N", int'(synchronizer0UT), 1);
    check("sync1_after_N", int'(synchronizer1OUT), 0);
    @(posedge clk);
    #1;
    check("sync1_after_N1", int'(synchronizer1OUT), 1);
    lat = 1;
    for (int k = 2; k < 20; k++) begin
      @(posedge clk);
      #1;
      lat = k;
      if (conditioned) break;
    end
    check("rise_latency", lat, WT + 2);
    check("posedge_pulse", int'(positiveedge), 1);
    check("negedge_quiet_rise", int'(negativeedge), 0);
    @(posedge clk);
    #1;
    check("posedge_one_cycle", int'(positiveedge), 0);

    // Falling input
    repeat (3) @(negedge clk);
    noisysignal = 1'b0;
    latency(1'b0, lat);
    check("fall_latency", lat, WT + 2);
    check("negedge_pulse", int'(negativeedge), 1);
    check("posedge_quiet_fall", int'(positiveedge), 0);
    @(posedge clk);
    #1;
    check("negedge_one_cycle", int'(negativeedge), 0);

    // 1 ns toggling burst that settles high
    repeat (3) @(negedge clk);
    pos0 = pos_seen;
    neg0 = neg_seen;
    #6;
    for (int i = 0; i < 7; i++) begin
      noisysignal = ~noisysignal;
      if (i < 6) #1;
    end
    latency(1'b1, lat);
    check("burst_latency", lat, WT + 2);
    repeat (3) @(negedge clk);
    check("burst_pos_pulses", pos_seen - pos0, 1);
    check("burst_neg_pulses", neg_seen - neg0, 0);

    // Return low, then a two-cycle high pulse must be rejected
    noisysignal = 1'b0;
    repeat (10) @(negedge clk);
    pos0 = pos_seen;
    neg0 = neg_seen;
    noisysignal = 1'b1;
    repeat (2) @(negedge clk);
    noisysignal = 1'b0;
    repeat (8) @(negedge clk);
    check("glitch_cond", int'(conditioned), 0);
    check("glitch_pos_pulses", pos_seen - pos0, 0);
    check("glitch_neg_pulses", neg_seen - neg0, 0);

    // Reset mid-debounce discards the partial count
    noisysignal = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_outputs", int'(outs), 0);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    latency(1'b1, lat);
    check("post_reset_latency", lat, WT + 2);
    check("post_reset_pulse", int'(positiveedge), 1);

    // Randomized stimulus, checked by the scoreboard
    for (int it = 0; it < 300; it++) begin
      @(negedge clk);
      mode = $urandom_range(0, 9);
      if (mode < 7) begin
        #($urandom_range(1, 4));
        noisysignal = 1'($urandom_range(0, 1));
        hold = $urandom_range(0, 6);
        repeat (hold) @(negedge clk);
      end else if (mode < 9) begin
        #6;
        hold = $urandom_range(1, 7);
        for (int i = 0; i < hold; i++) begin
          noisysignal = ~noisysignal;
          if (i < hold - 1) #1;
        end
      end else begin
        #($urandom_range(1, 4));
        reset_n = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b1;
      end
    end
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
